rv32_mem_arbiter: RTL
=====================

Name: rv32_mem_arbiter

Overview:
Shares one single-port memory bus between the RV32 core's instruction-fetch port and its load/store data port. Both sides use a req/gnt/rvalid handshake.
- Data port has priority over fetch.
- A streak limit guarantees fetch is never starved.
- Accepted transactions are tracked in an in-order ID FIFO, which routes each memory response back to its owner.
- Sits between the RV32 core and the shared instruction/data memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_OUTSTANDING, 2, accepted-but-unanswered transactions allowed (1..4)
DATA_STREAK_MAX, 4, consecutive data grants allowed while a fetch is waiting

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch read data valid
if_rdata_o  out  DATA_W  fetch read data
d_req_i  in  1  data request
d_we_i  in  1  1 = store, 0 = load
d_be_i  in  4  byte enables
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_gnt_o  out  1  data request accepted
d_rvalid_o  out  1  data response (load data, or store completion)
d_rdata_o  out  DATA_W  load data
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_be_o  out  4  memory byte enables
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory response valid (one per granted transaction, reads and writes)
mem_rdata_i  in  DATA_W  memory read data
err_o  out  1  sticky: response arrived with no outstanding transaction

Behaviour:
- Reset (rst_i=0, async): all outputs 0; ID FIFO empty; outstanding count 0; streak 0; lock cleared; err_o 0.
- Selection, when not locked:
  - d_req_i wins, unless streak==DATA_STREAK_MAX and if_req_i=1; then fetch wins.
  - Otherwise if_req_i wins.
  - No request: mem_req_o=0.
- Lock rule:
  - Once mem_req_o=1 toward a requester and mem_gnt_i=0, the selection is frozen until the grant.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o stay stable while locked, even if the other side raises its request.
- Forwarding is combinational:
  - mem_req_o = selected req AND NOT (count==MAX_OUTSTANDING AND mem_rvalid_i=0).
  - Fetch selected forces mem_we_o=0 and mem_be_o=4'hF.
- Grant:
  - x_gnt_o = mem_gnt_i AND mem_req_o AND (selected==x), combinational, same cycle.
  - At most one grant per cycle.
- On grant: push the requester ID into the FIFO and increment count.
- On mem_rvalid_i: pop the FIFO head and pulse the matching x_rvalid_o for 1 cycle.
  - x_rdata_o = mem_rdata_i, combinational, zero added latency.
  - The non-addressed rvalid stays 0.
  - Rdata of the non-addressed port is don't-care.
- Grant and rvalid in the same cycle: push and pop both occur; count unchanged.
  - This is allowed even when count==MAX_OUTSTANDING.
- Response ordering: strictly in order; the memory is required to answer in order.
- Streak counter:
  - +1 on each data grant while if_req_i=1, saturating at DATA_STREAK_MAX.
  - Cleared on fetch grant, or in any cycle with if_req_i=0.
- mem_rvalid_i with an empty FIFO (and no same-cycle push): no output pulse; err_o set sticky until reset.
- Reset mid-transaction: outstanding IDs are discarded. Any stale memory response after reset release hits an empty FIFO and sets err_o.

Decomposition:
- Package rv32_mem_pkg:
  - typedef enum logic {REQ_IF=1'b0, REQ_D=1'b1} req_id_t;
  - BE_FULL = 4'hF.
- Sub-module rv32_id_fifo:
  - Depth MAX_OUTSTANDING, holds req_id_t.
  - Simultaneous push/pop when full or empty-with-push; async active-low reset.
  - Exports count, empty and full.
- Arbiter top holds the lock/selection state, streak counter, forwarding muxes and err logic.

Test Plan:
1. Simultaneous first requests:
   - Stimulus: if_req_i=1 addr 0x00 and d_req_i=1 load addr 0x100 in the same cycle, mem_gnt_i=1.
   - Required: d_gnt_o first. Next cycle if_gnt_o. Responses 0xAAAA0000 then 0x11111111 arrive as d_rvalid_o then if_rvalid_o with matching rdata.
2. Fetch starvation guard:
   - Stimulus: d_req_i and if_req_i held high continuously, mem_gnt_i=1, DATA_STREAK_MAX=4.
   - Required: grant pattern D,D,D,D,IF,D,D,D,D,IF.
3. Lock under stall:
   - Stimulus: fetch selected, mem_gnt_i=0 for 3 cycles; d_req_i rises in cycle 2.
   - Required: mem_addr_o stays at the fetch address and no d_gnt_o until the fetch is granted in cycle 4.
4. Outstanding limit:
   - Stimulus: MAX_OUTSTANDING=2, two grants, no rvalid.
   - Required: mem_req_o=0 in the third cycle.
   - Then rvalid arrives in the same cycle as the pending request: mem_req_o=1 and the grant proceeds, count stays 2.
5. Store response routing:
   - Stimulus: store addr 0x40, data 0xDEADBEEF, be 4'b0011.
   - Required: mem_we_o=1, mem_be_o=4'b0011; the later rvalid pulses d_rvalid_o only.
6. Reset mid-transaction:
   - Stimulus: rst_i=0 while 2 transactions are outstanding, then release; memory sends 1 stale rvalid.
   - Required: all outputs 0 during reset. No if_rvalid_o/d_rvalid_o pulse on the stale rvalid; err_o=1 and held until the next reset.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_mem_pkg : shared types for the RV32 fetch/data memory arbiter  (rev 1.0)
// ---------------------------------------------------------------------------
package rv32_mem_pkg;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/rv32_id_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_id_fifo : in-order owner-ID FIFO with push/pop bypass  (rev 1.0)
// ---------------------------------------------------------------------------
module rv32_id_fifo
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  req_id_t          id_i,
  input  logic             pop_i,
  output req_id_t          id_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_t          slot_q [DEPTH];
  req_id_t          slot_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  // An empty FIFO popped in the same cycle it is pushed hands the new ID straight through.
  assign id_o    = empty_o ? id_i : slot_q[rd_ptr_q];

  assign wr_en = push_i && !(empty_o && pop_i) && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    if (wr_en) begin
      slot_d[wr_ptr_q] = id_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= REQ_IF;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_mem_arbiter : data-priority fetch/data arbiter onto one memory bus  (rev 1.0)
// ---------------------------------------------------------------------------
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(DATA_STREAK_MAX);

  logic                locked_q, locked_d;
  req_id_t             lock_id_q, lock_id_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                err_q, err_d;

  logic                sel_valid, sel_req, stall, req_int, grant, fifo_pop;
  req_id_t             sel_id, head_id;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty, fifo_full;

  always_comb begin
    sel_valid = 1'b0;
    sel_id    = REQ_IF;
    if (locked_q) begin
      sel_valid = 1'b1;
      sel_id    = lock_id_q;
    end else if (d_req_i && !((streak_q == STREAK_CAP) && if_req_i)) begin
      sel_valid = 1'b1;
      sel_id    = REQ_D;
    end else if (if_req_i) begin
      sel_valid = 1'b1;
      sel_id    = REQ_IF;
    end
  end

  assign sel_req  = sel_valid && ((sel_id == REQ_D) ? d_req_i : if_req_i);
  // A response in the same cycle frees a slot, so a full tracker may still accept.
  assign stall    = fifo_full && !mem_rvalid_i;
  assign req_int  = sel_req && !stall;
  assign grant    = req_int && mem_gnt_i;
  assign fifo_pop = mem_rvalid_i && (!fifo_empty || grant);

  rv32_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .push_i  (grant),
    .id_i    (sel_id),
    .pop_i   (fifo_pop),
    .id_o    (head_id),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Outputs are qualified with the reset input so the whole interface reads 0 while held in reset.
  assign mem_req_o   = rst_i && req_int;
  assign mem_we_o    = rst_i && sel_req && (sel_id == REQ_D) && d_we_i;
  assign mem_be_o    = !(rst_i && sel_req) ? 4'h0 : ((sel_id == REQ_D) ? d_be_i : BE_FULL);
  assign mem_addr_o  = !(rst_i && sel_req) ? '0 : ((sel_id == REQ_D) ? d_addr_i : if_addr_i);
  assign mem_wdata_o = (rst_i && sel_req && (sel_id == REQ_D)) ? d_wdata_i : '0;

  assign if_gnt_o    = rst_i && grant && (sel_id == REQ_IF);
  assign d_gnt_o     = rst_i && grant && (sel_id == REQ_D);
  assign if_rvalid_o = rst_i && fifo_pop && (head_id == REQ_IF);
  assign d_rvalid_o  = rst_i && fifo_pop && (head_id == REQ_D);
  assign if_rdata_o  = rst_i ? mem_rdata_i : '0;
  assign d_rdata_o   = rst_i ? mem_rdata_i : '0;
  assign err_o       = err_q;

  always_comb begin
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
    streak_d  = streak_q;
    err_d     = err_q;
    if (grant) begin
      locked_d = 1'b0;
    end else if (req_int) begin
      locked_d  = 1'b1;
      lock_id_d = sel_id;
    end else if (!sel_req) begin
      locked_d = 1'b0;
    end
    if (!if_req_i || (grant && (sel_id == REQ_IF))) begin
      streak_d = '0;
    end else if (grant && (sel_id == REQ_D) && (streak_q != STREAK_CAP)) begin
      streak_d = streak_q + 1'b1;
    end
    if (mem_rvalid_i && (fifo_count == '0) && !grant) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      locked_q  <= 1'b0;
      lock_id_q <= REQ_IF;
      streak_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
      streak_q  <= streak_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire
